// File: rtl/lane_block_sync_pkg.sv
// Shared constants, FSM state type and sync-header helper for the lane block synchronizer.
package lane_block_sync_pkg;

  localparam int unsigned DEF_NB_DATA_CODED = 66;
  localparam int unsigned DEF_NB_SH         = 2;
  localparam int unsigned DEF_LOCK_SH_CNT   = 64;
  localparam int unsigned DEF_UNLOCK_WINDOW = 1024;
  localparam int unsigned DEF_MAX_INV_SH    = 65;
  localparam int unsigned DEF_SLIP_WAIT     = 2;
  localparam int unsigned DEF_NB_INDEX      = 7;
  localparam int unsigned DEF_NB_SLIP_CNT   = 16;

  localparam logic [DEF_NB_SH-1:0] SH_DATA = 2'b01;
  localparam logic [DEF_NB_SH-1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TEST   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_SLIP   = 2'd3
  } sync_state_t;

  function automatic logic sh_is_valid(input logic [DEF_NB_SH-1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/lane_block_sync_if.sv
// Word-stream interface between the skew stages, the block synchronizer and the lane aligner.
interface lane_block_sync_if
  import lane_block_sync_pkg::*;
#(
  parameter int unsigned NB_DATA_CODED = DEF_NB_DATA_CODED,
  parameter int unsigned NB_INDEX      = DEF_NB_INDEX,
  parameter int unsigned NB_SLIP_CNT   = DEF_NB_SLIP_CNT
) ();

  logic                     i_enable;
  logic                     i_valid;
  logic [NB_DATA_CODED-1:0] i_data;
  logic [NB_DATA_CODED-1:0] o_data;
  logic                     o_valid;
  logic                     o_sh_valid;
  logic                     o_block_lock;
  logic [NB_INDEX-1:0]      o_bit_index;
  logic [NB_SLIP_CNT-1:0]   o_slip_count;

  modport master (
    output i_enable, i_valid, i_data,
    input  o_data, o_valid, o_sh_valid, o_block_lock, o_bit_index, o_slip_count
  );

  modport slave (
    input  i_enable, i_valid, i_data,
    output o_data, o_valid, o_sh_valid, o_block_lock, o_bit_index, o_slip_count
  );

endinterface

// File: rtl/lane_block_sync_bit_window_selector.sv
// Picks the 66b candidate block at bit offset i_index out of {prev, current} and flags its header.
module bit_window_selector
  import lane_block_sync_pkg::*;
#(
  parameter int unsigned NB_DATA_CODED = DEF_NB_DATA_CODED,
  parameter int unsigned NB_INDEX      = DEF_NB_INDEX
) (
  input  logic [2*NB_DATA_CODED-1:0] i_cat,
  input  logic [NB_INDEX-1:0]        i_index,
  output logic [NB_DATA_CODED-1:0]   o_blk,
  output logic                       o_sh_ok
);

  // cat[131-index -: 66] expressed as a right shift by (66 - index)
  always_comb begin
    o_blk   = NB_DATA_CODED'(i_cat >> (NB_INDEX'(NB_DATA_CODED) - i_index));
    o_sh_ok = sh_is_valid(o_blk[NB_DATA_CODED-1 -: DEF_NB_SH]);
  end

endmodule

// File: rtl/lane_block_sync.sv
// Per-lane 66b block synchronizer: sync-header slip search, lock/unlock hysteresis, aligned output.
module lane_block_sync
  import lane_block_sync_pkg::*;
#(
  parameter int unsigned NB_DATA_CODED = DEF_NB_DATA_CODED,
  parameter int unsigned LOCK_SH_CNT   = DEF_LOCK_SH_CNT,
  parameter int unsigned UNLOCK_WINDOW = DEF_UNLOCK_WINDOW,
  parameter int unsigned MAX_INV_SH    = DEF_MAX_INV_SH,
  parameter int unsigned SLIP_WAIT     = DEF_SLIP_WAIT,
  parameter int unsigned NB_INDEX      = DEF_NB_INDEX,
  parameter int unsigned NB_SLIP_CNT   = DEF_NB_SLIP_CNT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  lane_block_sync_if.slave  bus
);

  localparam int unsigned NB_SH_CNT  = $clog2(UNLOCK_WINDOW) + 1;
  localparam int unsigned NB_INV_CNT = $clog2(MAX_INV_SH) + 1;
  localparam int unsigned NB_WAIT    = $clog2(SLIP_WAIT) + 1;

  sync_state_t              state, state_nxt;
  logic [NB_SH_CNT-1:0]     sh_cnt, sh_cnt_nxt, sh_cnt_inc;
  logic [NB_INV_CNT-1:0]    inv_cnt, inv_cnt_nxt, inv_cnt_inc;
  logic [NB_WAIT-1:0]       wait_cnt, wait_cnt_nxt;
  logic                     slip;
  logic [NB_INDEX-1:0]      index;
  logic [NB_SLIP_CNT-1:0]   slip_cnt;
  logic [NB_DATA_CODED-1:0] prev, blk, o_data_q;
  logic                     sh_ok, o_valid_q, o_sh_valid_q;

  bit_window_selector #(
    .NB_DATA_CODED (NB_DATA_CODED),
    .NB_INDEX      (NB_INDEX)
  ) u_sel (
    .i_cat   ({prev, bus.i_data}),
    .i_index (index),
    .o_blk   (blk),
    .o_sh_ok (sh_ok)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_INIT;
      sh_cnt   <= '0;
      inv_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sh_cnt   <= sh_cnt_nxt;
      inv_cnt  <= inv_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sh_cnt_nxt   = sh_cnt;
    inv_cnt_nxt  = inv_cnt;
    wait_cnt_nxt = wait_cnt;
    slip         = 1'b0;
    sh_cnt_inc   = sh_cnt + 1'b1;
    inv_cnt_inc  = inv_cnt + NB_INV_CNT'(!sh_ok);
    if (!bus.i_enable) begin
      state_nxt    = ST_INIT;
      sh_cnt_nxt   = '0;
      inv_cnt_nxt  = '0;
      wait_cnt_nxt = '0;
    end else if (bus.i_valid) begin
      unique case (state)
        ST_INIT: begin
          state_nxt  = ST_TEST;
          sh_cnt_nxt = '0;
        end
        ST_TEST: begin
          if (!sh_ok) begin
            slip = 1'b1;
          end else if (sh_cnt_inc == NB_SH_CNT'(LOCK_SH_CNT)) begin
            state_nxt   = ST_LOCKED;
            sh_cnt_nxt  = '0;
            inv_cnt_nxt = '0;
          end else begin
            sh_cnt_nxt = sh_cnt_inc;
          end
        end
        ST_LOCKED: begin
          // Too many bad headers takes priority over closing the window on the same test
          if (inv_cnt_inc == NB_INV_CNT'(MAX_INV_SH)) begin
            slip = 1'b1;
          end else if (sh_cnt_inc == NB_SH_CNT'(UNLOCK_WINDOW)) begin
            sh_cnt_nxt  = '0;
            inv_cnt_nxt = '0;
          end else begin
            sh_cnt_nxt  = sh_cnt_inc;
            inv_cnt_nxt = inv_cnt_inc;
          end
        end
        ST_SLIP: begin
          if (wait_cnt == NB_WAIT'(SLIP_WAIT - 1)) begin
            state_nxt    = ST_TEST;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
      if (slip) begin
        state_nxt    = ST_SLIP;
        sh_cnt_nxt   = '0;
        inv_cnt_nxt  = '0;
        wait_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      index        <= '0;
      slip_cnt     <= '0;
      prev         <= '0;
      o_data_q     <= '0;
      o_sh_valid_q <= 1'b0;
      o_valid_q    <= 1'b0;
    end else begin
      if (slip) begin
        index <= (index == NB_INDEX'(NB_DATA_CODED - 1)) ? '0 : index + 1'b1;
        if (slip_cnt != '1) slip_cnt <= slip_cnt + 1'b1;
      end
      if (bus.i_valid) begin
        prev         <= bus.i_data;
        o_data_q     <= blk;
        o_sh_valid_q <= sh_ok;
      end
      o_valid_q <= bus.i_valid & bus.i_enable;
    end
  end

  assign bus.o_data       = o_data_q;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_sh_valid   = o_sh_valid_q;
  assign bus.o_block_lock = (state == ST_LOCKED);
  assign bus.o_bit_index  = index;
  assign bus.o_slip_count = slip_cnt;

endmodule

// File: tb/tb_lane_block_sync.sv
// Self-checking bench for lane_block_sync: PRBS31 66b blocks, rotated word stream, lock/unlock scenarios.
module tb_lane_block_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_block_sync_if bus ();

  lane_block_sync dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Transmit model: tx[] holds serial blocks in order; received word n = bits of
  // {tx[n], tx[n+1]} starting 'rot' bits before the boundary of tx[n+1].
  logic [65:0]  tx[$];
  bit           badq[$];
  int unsigned  wn;
  int unsigned  rot;
  logic [30:0]  prbs;

  function automatic logic [63:0] prbs64();
    logic [63:0] v;
    logic        nb;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      nb   = prbs[30] ^ prbs[27];
      prbs = {prbs[29:0], nb};
      v    = {v[62:0], nb};
    end
    return v;
  endfunction

  task automatic push_block(input bit bad);
    logic [1:0] sh;
    sh = bad ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
    tx.push_back({sh, prbs64()});
  endtask

  function automatic logic [65:0] word_of(input int unsigned n);
    logic [131:0] cat;
    cat = {tx[n], tx[n+1]};
    return cat[65 + rot -: 66];
  endfunction

  task automatic new_stream(input int unsigned r);
    tx.delete();
    badq.delete();
    wn   = 0;
    rot  = r;
    prbs = 31'($urandom) | 31'd1;
    push_block(1'b0);
    push_block(1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word();
    bit b;
    if (tx.size() < int'(wn) + 2) begin
      b = (badq.size() > 0) ? badq.pop_front() : 1'b0;
      push_block(b);
    end
    bus.i_data  = word_of(wn);
    bus.i_valid = 1'b1;
    tick();
    wn++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_enable = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (bus.o_data !== 66'd0)       begin fails++; $display("FAIL reset_data got %h expected 0", bus.o_data); end
    tests++; if (bus.o_valid !== 1'b0)       begin fails++; $display("FAIL reset_valid got %b expected 0", bus.o_valid); end
    tests++; if (bus.o_sh_valid !== 1'b0)    begin fails++; $display("FAIL reset_sh_valid got %b expected 0", bus.o_sh_valid); end
    tests++; if (bus.o_block_lock !== 1'b0)  begin fails++; $display("FAIL reset_lock got %b expected 0", bus.o_block_lock); end
    tests++; if (bus.o_bit_index !== 7'd0)   begin fails++; $display("FAIL reset_index got %0d expected 0", bus.o_bit_index); end
    tests++; if (bus.o_slip_count !== 16'd0) begin fails++; $display("FAIL reset_slips got %0d expected 0", bus.o_slip_count); end
    rst = 1'b0;
  endtask

  task automatic test_lock_index0();
    new_stream(0);
    bus.i_enable = 1'b1;
    for (int k = 0; k < 65; k++) begin
      send_word();
      tests++;
      if (bus.o_block_lock !== (k == 64)) begin
        fails++; $display("FAIL lock0_lock valid#%0d got %b expected %b", k + 1, bus.o_block_lock, (k == 64));
      end
      tests++;
      if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL lock0_valid valid#%0d got %b expected 1", k + 1, bus.o_valid); end
      if (k > 0) begin
        tests++;
        if (bus.o_data !== tx[k]) begin fails++; $display("FAIL lock0_data word %0d got %h expected %h", k, bus.o_data, tx[k]); end
        tests++;
        if (bus.o_sh_valid !== 1'b1) begin fails++; $display("FAIL lock0_sh word %0d got %b expected 1", k, bus.o_sh_valid); end
      end
    end
    tests++; if (bus.o_bit_index !== 7'd0)   begin fails++; $display("FAIL lock0_index got %0d expected 0", bus.o_bit_index); end
    tests++; if (bus.o_slip_count !== 16'd0) begin fails++; $display("FAIL lock0_slips got %0d expected 0", bus.o_slip_count); end
  endtask

  // Starts locked at index 0 right after the locking word; window 1 gets 64 bad headers,
  // window 2 gets 65 and must unlock on the test of the last one.
  task automatic test_unlock_window();
    bit fl1[1024];
    bit fl2[1024];
    int cnt;
    int p;
    int last;
    foreach (fl1[i]) fl1[i] = 1'b0;
    foreach (fl2[i]) fl2[i] = 1'b0;
    cnt = 0;
    while (cnt < 64) begin
      p = int'($urandom_range(1, 1023));
      if (!fl1[p]) begin fl1[p] = 1'b1; cnt++; end
    end
    cnt  = 0;
    last = 0;
    while (cnt < 65) begin
      p = int'($urandom_range(0, 1023));
      if (!fl2[p]) begin fl2[p] = 1'b1; cnt++; if (p > last) last = p; end
    end
    for (int i = 1; i < 1024; i++) badq.push_back(fl1[i]);
    for (int i = 0; i < 1024; i++) badq.push_back(fl2[i]);
    for (int k = 0; k < 1024; k++) begin
      send_word();
      tests++;
      if (bus.o_block_lock !== 1'b1) begin fails++; $display("FAIL win1_lock test %0d got %b expected 1", k, bus.o_block_lock); end
    end
    for (int k = 0; k <= last; k++) begin
      send_word();
      tests++;
      if (bus.o_block_lock !== (k != last)) begin
        fails++; $display("FAIL win2_lock test %0d got %b expected %b", k, bus.o_block_lock, (k != last));
      end
    end
    tests++; if (bus.o_bit_index !== 7'd1)   begin fails++; $display("FAIL unlock_index got %0d expected 1", bus.o_bit_index); end
    tests++; if (bus.o_slip_count !== 16'd1) begin fails++; $display("FAIL unlock_slips got %0d expected 1", bus.o_slip_count); end
  endtask

  task automatic test_valid_toggle();
    int nvalid;
    pulse_reset();
    new_stream(0);
    bus.i_enable = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 130; c++) begin
      if (c % 2 == 0) begin
        send_word();
        nvalid++;
      end else begin
        bus.i_valid = 1'b0;
        bus.i_data  = {2'($urandom), $urandom, $urandom};
        tick();
      end
      tests++;
      if (bus.o_valid !== (c % 2 == 0)) begin
        fails++; $display("FAIL toggle_valid clk %0d got %b expected %b", c, bus.o_valid, (c % 2 == 0));
      end
      tests++;
      if (bus.o_block_lock !== (nvalid >= 65)) begin
        fails++; $display("FAIL toggle_lock clk %0d got %b expected %b", c, bus.o_block_lock, (nvalid >= 65));
      end
    end
  endtask

  task automatic search_lock(input string name);
    int n;
    n = 0;
    while (bus.o_block_lock !== 1'b1 && n < 4000) begin
      send_word();
      n++;
    end
    tests++; if (bus.o_block_lock !== 1'b1)   begin fails++; $display("FAIL %s_timeout got lock %b expected 1 within 4000 words", name, bus.o_block_lock); end
    tests++; if (bus.o_bit_index !== 7'd17)   begin fails++; $display("FAIL %s_index got %0d expected 17", name, bus.o_bit_index); end
    tests++; if (bus.o_slip_count !== 16'd17) begin fails++; $display("FAIL %s_slips got %0d expected 17", name, bus.o_slip_count); end
  endtask

  task automatic test_rotated();
    pulse_reset();
    new_stream(17);
    bus.i_enable = 1'b1;
    search_lock("rot17");
    for (int k = 0; k < 32; k++) begin
      send_word();
      tests++;
      if (bus.o_data !== tx[wn-1]) begin fails++; $display("FAIL rot17_data word %0d got %h expected %h", wn - 1, bus.o_data, tx[wn-1]); end
      tests++;
      if (bus.o_sh_valid !== 1'b1) begin fails++; $display("FAIL rot17_sh word %0d got %b expected 1", wn - 1, bus.o_sh_valid); end
      tests++;
      if (bus.o_block_lock !== 1'b1) begin fails++; $display("FAIL rot17_hold word %0d got %b expected 1", wn - 1, bus.o_block_lock); end
    end
  endtask

  task automatic test_enable_low();
    bus.i_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      send_word();
      tests++; if (bus.o_block_lock !== 1'b0) begin fails++; $display("FAIL en_lock cyc %0d got %b expected 0", k, bus.o_block_lock); end
      tests++; if (bus.o_valid !== 1'b0)      begin fails++; $display("FAIL en_valid cyc %0d got %b expected 0", k, bus.o_valid); end
      tests++; if (bus.o_bit_index !== 7'd17) begin fails++; $display("FAIL en_index cyc %0d got %0d expected 17", k, bus.o_bit_index); end
    end
    bus.i_enable = 1'b1;
    for (int k = 0; k < 65; k++) begin
      send_word();
      tests++;
      if (bus.o_block_lock !== (k == 64)) begin
        fails++; $display("FAIL reen_lock valid#%0d got %b expected %b", k + 1, bus.o_block_lock, (k == 64));
      end
    end
    tests++; if (bus.o_slip_count !== 16'd17) begin fails++; $display("FAIL reen_slips got %0d expected 17", bus.o_slip_count); end
    tests++; if (bus.o_bit_index !== 7'd17)   begin fails++; $display("FAIL reen_index got %0d expected 17", bus.o_bit_index); end
  endtask

  task automatic test_async_reset();
    tests++; if (bus.o_block_lock !== 1'b1) begin fails++; $display("FAIL arst_pre_lock got %b expected 1", bus.o_block_lock); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.o_data !== 66'd0)       begin fails++; $display("FAIL arst_data got %h expected 0", bus.o_data); end
    tests++; if (bus.o_valid !== 1'b0)       begin fails++; $display("FAIL arst_valid got %b expected 0", bus.o_valid); end
    tests++; if (bus.o_sh_valid !== 1'b0)    begin fails++; $display("FAIL arst_sh_valid got %b expected 0", bus.o_sh_valid); end
    tests++; if (bus.o_block_lock !== 1'b0)  begin fails++; $display("FAIL arst_lock got %b expected 0", bus.o_block_lock); end
    tests++; if (bus.o_bit_index !== 7'd0)   begin fails++; $display("FAIL arst_index got %0d expected 0", bus.o_bit_index); end
    tests++; if (bus.o_slip_count !== 16'd0) begin fails++; $display("FAIL arst_slips got %0d expected 0", bus.o_slip_count); end
    tick();
    rst = 1'b0;
    new_stream(17);
    search_lock("relock");
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_index0();
    test_unlock_window();
    test_valid_toggle();
    test_rotated();
    test_enable_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
